mult_fu: RTL

Pipelined integer multiply functional unit that consumes one issued instruction per cycle from the reservation station's issue port. It computes the RV32M MUL/MULH/MULHSU/MULHU result over `STAGES` cycles and presents it for CDB broadcast. It holds a result until granted. It drives one bit of the reservation station's `ALU_occupied` vector so that nothing is issued when it cannot accept.

---
 rtl/mult_fu.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mult_fu.sv
// Pipelined RV32M multiply unit: shift-and-add over STAGES chunks of the multiplier,
// with bubble-collapsing stalls and a held result until the CDB grants it.
module mult_fu #(
  parameter int XLEN   = 32,
  parameter int PRF    = 64,
  parameter int STAGES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic [XLEN-1:0]         issue_opa,
  input  logic [XLEN-1:0]         issue_opb,
  input  logic [1:0]              issue_func,
  input  logic [$clog2(PRF)-1:0]  issue_dest_prf,
  input  logic                    squash,
  output logic                    occupied,
  input  logic                    cdb_grant,
  output logic                    out_valid,
  output logic [XLEN-1:0]         out_data,
  output logic [$clog2(PRF)-1:0]  out_prf_idx
);

  localparam int PW = 2 * XLEN;
  localparam int CW = PW / STAGES;
  localparam int TW = $clog2(PRF);

  localparam logic [1:0] F_MUL    = 2'd0;
  localparam logic [1:0] F_MULH   = 2'd1;
  localparam logic [1:0] F_MULHSU = 2'd2;

  // Partial product of the multiplicand with the low CW bits of the remaining multiplier.
  function automatic logic [PW-1:0] part_prod(input logic [PW-1:0] mcand,
                                              input logic [PW-1:0] mplier);
    logic [PW-1:0] chunk;
    chunk           = '0;
    chunk[CW-1:0]   = mplier[CW-1:0];
    return mcand * chunk;
  endfunction

  logic              r_vld    [STAGES];
  logic [TW-1:0]     r_tag    [STAGES];
  logic [1:0]        r_func   [STAGES];
  logic [PW-1:0]     r_mcand  [STAGES];
  logic [PW-1:0]     r_mplier [STAGES];
  logic [PW-1:0]     r_psum   [STAGES];

  logic [STAGES-1:0] w_adv;
  logic              w_ld0;
  logic              w_accept;
  logic [PW-1:0]     w_ext_a;
  logic [PW-1:0]     w_ext_b;
  logic [PW-1:0]     w_result;

  // Each stage may move on if any later stage is a bubble or the head is granted.
  always_comb begin
    logic acc;
    w_adv             = '0;
    acc               = !r_vld[STAGES-1] || cdb_grant;
    w_adv[STAGES-1]   = acc;
    for (int i = STAGES - 2; i >= 0; i--) begin
      acc      = !r_vld[i+1] || acc;
      w_adv[i] = acc;
    end
  end

  assign w_ld0    = !r_vld[0] || w_adv[0];
  assign occupied = !w_ld0;
  assign w_accept = issue_valid && w_ld0;

  always_comb begin
    w_ext_a = {{XLEN{1'b0}}, issue_opa};
    w_ext_b = {{XLEN{1'b0}}, issue_opb};
    if (issue_func == F_MULH || issue_func == F_MULHSU)
      w_ext_a = {{XLEN{issue_opa[XLEN-1]}}, issue_opa};
    if (issue_func == F_MULH)
      w_ext_b = {{XLEN{issue_opb[XLEN-1]}}, issue_opb};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        r_vld[i]    <= 1'b0;
        r_tag[i]    <= '0;
        r_func[i]   <= '0;
        r_mcand[i]  <= '0;
        r_mplier[i] <= '0;
        r_psum[i]   <= '0;
      end
    end else begin
      // stage 0: latch extended operands from the issue port
      if (w_ld0) begin
        r_vld[0]    <= w_accept;
        r_tag[0]    <= issue_dest_prf;
        r_func[0]   <= issue_func;
        r_mcand[0]  <= w_ext_a;
        r_mplier[0] <= w_ext_b;
        r_psum[0]   <= '0;
      end
      // stage i: fold in chunk i-1, then realign multiplicand and multiplier
      for (int i = 1; i < STAGES; i++) begin
        if (w_adv[i-1]) begin
          r_vld[i]    <= r_vld[i-1];
          r_tag[i]    <= r_tag[i-1];
          r_func[i]   <= r_func[i-1];
          r_mcand[i]  <= r_mcand[i-1] << CW;
          r_mplier[i] <= r_mplier[i-1] >> CW;
          r_psum[i]   <= r_psum[i-1] + part_prod(r_mcand[i-1], r_mplier[i-1]);
        end
      end
      if (squash) begin
        for (int i = 0; i < STAGES; i++) r_vld[i] <= 1'b0;
      end
    end
  end

  // output: last chunk is added combinationally from the head stage's registers
  assign w_result    = r_psum[STAGES-1] + part_prod(r_mcand[STAGES-1], r_mplier[STAGES-1]);
  assign out_valid   = r_vld[STAGES-1];
  assign out_prf_idx = r_tag[STAGES-1];
  assign out_data    = (r_func[STAGES-1] == F_MUL) ? w_result[XLEN-1:0] : w_result[PW-1:XLEN];

endmodule
